// File: rtl/pipelined_control_unit.sv
// RV32I main decoder registered into the ID/EX boundary with a valid/ready handshake.
// Holds one instruction, inserts a single bubble on load-use hazards and counts those bubbles.
module pipelined_control_unit #(
    parameter bit ENABLE_M      = 1'b0,
    parameter bit ENABLE_SYSTEM = 1'b1,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [16:0]      out_ctrl,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [2:0]       out_funct3,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [6:0]  OP_R      = 7'b0110011;
    localparam logic [6:0]  OP_I      = 7'b0010011;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_JALR   = 7'b1100111;
    localparam logic [6:0]  OP_FENCE  = 7'b0001111;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_LUI    = 7'b0110111;
    localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_SYSTEM = 7'b1110011;
    localparam logic [16:0] CTRL_ILLEGAL = 17'h10000;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Bit layout: [16]Illegal [15]Trap [14]MulDiv [13]ZeroOp [12]Jump [11]Branch [10]MemWrite
    // [9]MemRead [8]RegWrite [7]ALUSrc [6:5]RegSrc [4:3]ALUOp [2:0]ValidReg{rs2,rs1,rd}
    function automatic logic [16:0] decode_ctrl(input logic [31:0] instr);
        logic [16:0] c;
        c = 17'h00100;
        case (instr[6:0])
            OP_R: begin
                c[2:0] = 3'b111;
                if (instr[31:25] == 7'b0000001) begin
                    if (ENABLE_M) c[14] = 1'b1;
                    else          c = CTRL_ILLEGAL;
                end else begin
                    c[14] = 1'b0;
                end
            end
            OP_I:      begin c[7] = 1'b1; c[2:0] = 3'b011; end
            OP_LOAD:   begin c[4:3] = 2'd1; c[7] = 1'b1; c[9] = 1'b1; c[6:5] = 2'd1; c[2:0] = 3'b011; end
            OP_JALR:   begin c[6:5] = 2'd3; c[7] = 1'b1; c[12] = 1'b1; c[2:0] = 3'b011; end
            OP_FENCE:  begin c[8] = 1'b0; c[2:0] = 3'b011; end
            OP_STORE:  begin c[4:3] = 2'd1; c[7] = 1'b1; c[8] = 1'b0; c[10] = 1'b1; c[2:0] = 3'b110; end
            OP_LUI:    begin c[4:3] = 2'd1; c[7] = 1'b1; c[13] = 1'b1; c[2:0] = 3'b001; end
            OP_AUIPC:  begin c[6:5] = 2'd2; c[2:0] = 3'b001; end
            OP_JAL:    begin c[6:5] = 2'd3; c[12] = 1'b1; c[2:0] = 3'b001; end
            OP_BRANCH: begin c[4:3] = 2'd2; c[8] = 1'b0; c[11] = 1'b1; c[2:0] = 3'b110; end
            OP_SYSTEM: begin
                if (ENABLE_SYSTEM) begin c[8] = 1'b0; c[15] = 1'b1; c[2:0] = 3'b000; end
                else               c = CTRL_ILLEGAL;
            end
            default:   c = CTRL_ILLEGAL;
        endcase
        return c;
    endfunction

    logic [16:0]      dec_ctrl_s;
    logic             hazard_s;
    logic             in_ready_s;
    logic             out_valid_r;
    logic [16:0]      ctrl_r;
    logic [4:0]       rd_r;
    logic [4:0]       rs1_r;
    logic [4:0]       rs2_r;
    logic [2:0]       funct3_r;
    logic [CNT_W-1:0] stall_cnt_r;

    // Decode, load-use hazard against the held load, and input acceptance.
    always_comb begin
        dec_ctrl_s = decode_ctrl(in_instr);
        hazard_s   = out_valid_r & ctrl_r[9] & (rd_r != 5'd0) & in_valid &
                     ((dec_ctrl_s[1] & (in_instr[19:15] == rd_r)) |
                      (dec_ctrl_s[2] & (in_instr[24:20] == rd_r)));
        in_ready_s = (~out_valid_r | out_ready) & ~hazard_s & ~flush;
    end

    // ID/EX register: flush beats load beats drain; fields hold while the slot is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            ctrl_r      <= 17'h00000;
            rd_r        <= 5'd0;
            rs1_r       <= 5'd0;
            rs2_r       <= 5'd0;
            funct3_r    <= 3'd0;
        end else if (flush) begin
            out_valid_r <= 1'b0;
        end else if (in_valid && in_ready_s) begin
            out_valid_r <= 1'b1;
            ctrl_r      <= dec_ctrl_s;
            rd_r        <= in_instr[11:7];
            rs1_r       <= in_instr[19:15];
            rs2_r       <= in_instr[24:20];
            funct3_r    <= in_instr[14:12];
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Saturating bubble counter: only bubbles that actually enter EX are counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (hazard_s && out_ready && !flush && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign in_ready    = in_ready_s;
    assign out_valid   = out_valid_r;
    assign out_ctrl    = ctrl_r;
    assign out_rd      = rd_r;
    assign out_rs1     = rs1_r;
    assign out_rs2     = rs2_r;
    assign out_funct3  = funct3_r;
    assign stall_count = stall_cnt_r;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed bench for pipelined_control_unit: expected bundles are queued at acceptance
// and compared when the DUT presents them to EX.
module tb_pipelined_control_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        out_ready;

    logic        in_ready, out_valid;
    logic [16:0] out_ctrl;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [2:0]  out_funct3;
    logic [15:0] stall_count;

    logic        m_in_ready, m_out_valid;
    logic [16:0] m_out_ctrl;
    logic [4:0]  m_out_rd, m_out_rs1, m_out_rs2;
    logic [2:0]  m_out_funct3;
    logic [1:0]  m_stall_count;

    int checks = 0;
    int errors = 0;
    logic [21:0] sb[$];

    localparam logic [31:0] ADD   = 32'h002081B3;
    localparam logic [31:0] LW5   = 32'h0000A283;
    localparam logic [31:0] ADD6  = 32'h00128333;
    localparam logic [31:0] LW0   = 32'h0000A003;
    localparam logic [31:0] ADDX0 = 32'h00100333;
    localparam logic [31:0] MUL   = 32'h022081B3;
    localparam logic [31:0] ILL   = 32'h0000007F;
    localparam logic [31:0] SW    = 32'h0020A023;
    localparam logic [31:0] BEQ   = 32'h00208063;
    localparam logic [31:0] LUI   = 32'h000010B7;
    localparam logic [31:0] JAL   = 32'h000000EF;
    localparam logic [31:0] ECALL = 32'h00000073;
    localparam logic [31:0] ADDI  = 32'h00100093;

    always #5 clk = ~clk;

    pipelined_control_unit dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct3(out_funct3),
        .stall_count(stall_count)
    );

    pipelined_control_unit #(.ENABLE_M(1'b1), .ENABLE_SYSTEM(1'b1), .CNT_W(2)) dut_m (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(m_in_ready),
        .in_instr(in_instr), .out_valid(m_out_valid), .out_ready(out_ready), .out_ctrl(m_out_ctrl),
        .out_rd(m_out_rd), .out_rs1(m_out_rs1), .out_rs2(m_out_rs2), .out_funct3(m_out_funct3),
        .stall_count(m_stall_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs, check at negedge, queue the bundle if it is taken.
    task automatic step(input logic v, input logic [31:0] ins, input logic ordy, input logic fl,
                        input logic exp_rdy, input logic exp_ov, input logic [16:0] exp_ctrl);
        logic [21:0] e;
        in_valid = v; in_instr = ins; out_ready = ordy; flush = fl;
        @(negedge clk);
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
        if (exp_ov) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL scoreboard_empty observed=out_valid expected=no_output");
            end else begin
                e = ordy ? sb.pop_front() : sb[0];
                chk("out_ctrl", {15'd0, out_ctrl}, {15'd0, e[21:5]});
                chk("out_rd", {27'd0, out_rd}, {27'd0, e[4:0]});
            end
        end
        if (v && exp_rdy) sb.push_back({exp_ctrl, ins[11:7]});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = 32'd0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_ctrl", {15'd0, out_ctrl}, 32'd0);
        chk("rst_stall", {16'd0, stall_count}, 32'd0);
        chk("rst_fields", {14'd0, out_rd, out_rs1, out_rs2, out_funct3}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic decode stream and load-use bubble.
        step(1'b1, ADD,  1'b1, 1'b0, 1'b1, 1'b0, 17'h00107);
        step(1'b1, LW5,  1'b1, 1'b0, 1'b1, 1'b1, 17'h003AB);
        step(1'b1, ADD6, 1'b1, 1'b0, 1'b0, 1'b1, 17'h00000);
        chk("stall_after_hazard", {16'd0, stall_count}, 32'd1);
        step(1'b1, ADD6, 1'b1, 1'b0, 1'b1, 1'b0, 17'h00107);
        step(1'b1, LW0,  1'b1, 1'b0, 1'b1, 1'b1, 17'h003AB);
        step(1'b1, ADDX0,1'b1, 1'b0, 1'b1, 1'b1, 17'h00107);
        chk("stall_x0_load", {16'd0, stall_count}, 32'd1);
        step(1'b1, MUL,  1'b1, 1'b0, 1'b1, 1'b1, 17'h10000);
        chk("mul_enable_m", {15'd0, m_out_ctrl}, 32'h00004107);
        step(1'b1, ILL,  1'b1, 1'b0, 1'b1, 1'b1, 17'h10000);
        step(1'b1, SW,   1'b1, 1'b0, 1'b1, 1'b1, 17'h0048E);
        step(1'b1, BEQ,  1'b1, 1'b0, 1'b1, 1'b1, 17'h00816);
        step(1'b1, LUI,  1'b1, 1'b0, 1'b1, 1'b1, 17'h02189);
        step(1'b1, JAL,  1'b1, 1'b0, 1'b1, 1'b1, 17'h01161);
        step(1'b1, ECALL,1'b1, 1'b0, 1'b1, 1'b1, 17'h08000);
        step(1'b0, 32'd0,1'b1, 1'b0, 1'b1, 1'b1, 17'h00000);

        // Backpressure: held bundle stable for three cycles, then drains in order.
        step(1'b1, ADD,  1'b1, 1'b0, 1'b1, 1'b0, 17'h00107);
        for (int i = 0; i < 3; i++) step(1'b1, ADDI, 1'b0, 1'b0, 1'b0, 1'b1, 17'h00000);
        step(1'b1, ADDI, 1'b1, 1'b0, 1'b1, 1'b1, 17'h00183);
        step(1'b0, 32'd0,1'b1, 1'b0, 1'b1, 1'b1, 17'h00000);

        // Flush with an offered instruction: nothing is taken.
        step(1'b1, ADD,  1'b1, 1'b1, 1'b0, 1'b0, 17'h00000);
        step(1'b0, 32'd0,1'b1, 1'b0, 1'b1, 1'b0, 17'h00000);

        // Flush during a hazard stall: slot empties and the bubble is not counted.
        step(1'b1, LW5,  1'b1, 1'b0, 1'b1, 1'b0, 17'h003AB);
        step(1'b1, ADD6, 1'b0, 1'b0, 1'b0, 1'b1, 17'h00000);
        chk("stall_hazard_no_ready", {16'd0, stall_count}, 32'd1);
        step(1'b1, ADD6, 1'b1, 1'b1, 1'b0, 1'b1, 17'h00000);
        chk("stall_hazard_flush", {16'd0, stall_count}, 32'd1);
        step(1'b0, 32'd0,1'b1, 1'b0, 1'b1, 1'b0, 17'h00000);

        // Four more bubbles: the 2-bit counter saturates instead of wrapping.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, LW5,  1'b1, 1'b0, 1'b1, 1'b0, 17'h003AB);
            step(1'b1, ADD6, 1'b1, 1'b0, 1'b0, 1'b1, 17'h00000);
            step(1'b0, 32'd0,1'b1, 1'b0, 1'b1, 1'b0, 17'h00000);
        end
        chk("stall_count_5", {16'd0, stall_count}, 32'd5);
        chk("stall_saturate", {30'd0, m_stall_count}, 32'd3);

        // Asynchronous reset while a bundle is held.
        step(1'b1, ADD,  1'b1, 1'b0, 1'b1, 1'b0, 17'h00107);
        chk("pre_reset_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst_ctrl", {15'd0, out_ctrl}, 32'd0);
        chk("async_rst_stall", {16'd0, stall_count}, 32'd0);
        chk("async_rst_stall_m", {30'd0, m_stall_count}, 32'd0);
        chk("async_rst_rd", {27'd0, out_rd}, 32'd0);
        sb.delete();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
